muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative 8-bit multiply/divide execution unit for the CPU.
- Sits directly upstream of the register file. It accepts two operands (typically rX and r0) plus a destination register index, computes over several cycles, then drives one register-file write through rf_write_en / rf_write_addr / rf_in.
- The control unit stalls on busy and resumes on done.

Parameters:
- WIDTH, 8, operand and result width in bits; the iteration count equals WIDTH.
- ADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  operation: 0 = MUL_LO, 1 = MUL_HI, 2 = DIV (quotient), 3 = MOD (remainder).
- a  input  WIDTH  multiplicand / dividend (unsigned).
- b  input  WIDTH  multiplier / divisor (unsigned).
- dest_addr  input  ADDR_W  destination register for the result.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when the result is written.
- rf_write_en  output  1  register-file write strobe.
- rf_write_addr  output  ADDR_W  register-file write address.
- rf_in  output  WIDTH  register-file write data.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. busy, done, rf_write_en = 0; rf_write_addr = 0; rf_in = 0; all internal registers cleared. Asserting rst mid-operation aborts it; no write is ever issued for the aborted operation.
- States:
  - IDLE: busy = 0. When start = 1, capture a, b, op, dest_addr into internal registers, clear the accumulator, load counter = WIDTH, go to RUN.
  - RUN: busy = 1. One iteration per cycle; decrement the counter; when the counter reaches 1, go to WRITE on the next edge.
  - WRITE: busy = 1, rf_write_en = 1, done = 1 for exactly this cycle; rf_write_addr = captured dest_addr. Return to IDLE.
- Latency:
  - start sampled at edge N; RUN occupies cycles N+1..N+8; WRITE at cycle N+9.
  - Total of 9 cycles from start to write; back-to-back start is accepted in the cycle after WRITE.
- Inputs are captured only at start. Changes to a, b, op or dest_addr while busy have no effect.
- start while busy is ignored: not queued, no error.
- Multiply:
  - Unsigned shift-add with a 2*WIDTH-bit product register.
  - Each iteration: if the multiplier LSB = 1, add the multiplicand to the upper half, then shift the product right by 1, with the carry entering the MSB.
  - MUL_LO writes product[WIDTH-1:0]; MUL_HI writes product[2*WIDTH-1:WIDTH].
- Divide:
  - Unsigned restoring division.
  - Each iteration: shift the {remainder, quotient} pair left by 1; trial-subtract b from the remainder; if there is no borrow, keep the difference and set the quotient LSB.
  - DIV writes the quotient; MOD writes the remainder.
- Divide by zero: full 8 iterations still run (same latency); DIV writes 0xFF, MOD writes a. No flag is raised.
- rf_in and rf_write_addr hold their last values outside WRITE. Consumers qualify them with rf_write_en only.
- done and rf_write_en are asserted together and never outside WRITE.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: full behaviour above; divider datapath present.
- Undefined:
  - Divider logic is omitted.
  - op = 2 or 3 skips RUN: IDLE -> WRITE in one cycle (write at cycle N+1), with rf_in = 0x00, done pulses normally.
  - MUL ops are unchanged.

Test Plan:
- Reset, then a=13, b=11, op=MUL_LO, dest=4, start -> busy high cycles N+1..N+9; at N+9 rf_write_en=1, rf_write_addr=4, rf_in=0x8F, done=1; busy=0 at N+10.
- a=200, b=200, op=MUL_HI, dest=5 -> rf_in=0x9C; repeat with MUL_LO -> rf_in=0x40.
- a=200, b=7: DIV, dest=6 -> rf_in=0x1C; MOD, dest=7 -> rf_in=0x04 (MULDIV_DIV_EN defined).
- a=0x5A, b=0: DIV -> rf_in=0xFF; MOD -> rf_in=0x5A; both written at N+9. With the macro undefined, DIV writes 0x00 at N+1.
- Start MUL_LO 3*3; pulse start with a=9, b=9 at N+3; assert rst at N+5 -> rf_write_en never asserted; busy=0 immediately at reset; new start after reset writes 0x51 (9*9) after 9 cycles.
- Back-to-back: start in the cycle after done with a=255, b=255, MUL_HI -> second write occurs 9 cycles later with rf_in=0xFE.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned 8-bit MUL/DIV unit; 9 cycles from start to register-file write, ignores start while busy.
// Divider datapath is built only with MULDIV_DIV_EN; without it DIV/MOD write 0x00 one cycle after start.
module muldiv_unit #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [WIDTH-1:0]  rf_in
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     opnd_q;
  logic                 hi_q;
  logic [ADDR_W-1:0]    dest_q;

  // acc = {upper accumulator, multiplier}; carry of the add lands in the MSB on the shift
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_nxt;

  // acc = {remainder, quotient}; the shifted remainder needs one extra bit for the compare
  always_comb begin
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_rem = div_sh[WIDTH-1:0] - opnd_q;
    if (div_ge)
      div_nxt = {div_rem, acc[WIDTH-2:0], 1'b1};
    else
      div_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    acc_nxt = div_q ? div_nxt : mul_nxt;
  end
`else
  assign acc_nxt = mul_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      opnd_q        <= '0;
      hi_q          <= 1'b0;
      dest_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_in         <= '0;
`ifdef MULDIV_DIV_EN
      div_q         <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      rf_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hi_q   <= op[0];
            dest_q <= dest_addr;
            busy   <= 1'b1;
            cnt    <= CNT_W'(WIDTH);
`ifdef MULDIV_DIV_EN
            div_q  <= op[1];
            opnd_q <= op[1] ? b : a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            state  <= RUN;
`else
            opnd_q <= a;
            acc    <= {{WIDTH{1'b0}}, b};
            if (op[1]) begin
              state         <= WRITE;
              done          <= 1'b1;
              rf_write_en   <= 1'b1;
              rf_write_addr <= dest_addr;
              rf_in         <= '0;
            end else begin
              state <= RUN;
            end
`endif
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state         <= WRITE;
            done          <= 1'b1;
            rf_write_en   <= 1'b1;
            rf_write_addr <= dest_q;
            rf_in         <= hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-write scoreboard.
module tb_muldiv_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [2:0] dest_addr = 3'd0;
  logic       busy, done, rf_write_en;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_in;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DIV_LAT = DIV_ON ? 9 : 1;

  muldiv_unit #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .dest_addr    (dest_addr),
    .busy         (busy),
    .done         (done),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_in        (rf_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; start is sampled at the next posedge.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] xa,
                       input logic [7:0] xb, input logic [2:0] d, input logic [7:0] exp_data,
                       input int lat);
    exp_t e;
    int n;
    exp_q.push_back('{addr: d, data: exp_data});
    op = o; a = xa; b = xb; dest_addr = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~xa; b = ~xb; op = ~o; dest_addr = ~d;
    n = 1;
    while (!rf_write_en && n < 20) begin
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      start = (n == 3);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, "_wen"}, 32'(rf_write_en), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_wr"}, 32'(busy), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_addr"}, 32'(rf_write_addr), 32'(e.addr));
    check({tag, "_data"}, 32'(rf_in), 32'(e.data));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_wen_after"}, 32'(rf_write_en), 32'd0);
    check({tag, "_hold"}, 32'(rf_in), 32'(e.data));
  endtask

  initial begin
    int seen;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(rf_write_en), 32'd0);
    check("rst_addr", 32'(rf_write_addr), 32'd0);
    check("rst_data", 32'(rf_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("mul_lo_13x11", 2'd0, 8'd13, 8'd11, 3'd4, 8'h8F, 9);
    do_op("mul_hi_200", 2'd1, 8'd200, 8'd200, 3'd5, 8'h9C, 9);
    do_op("mul_lo_200", 2'd0, 8'd200, 8'd200, 3'd5, 8'h40, 9);
    do_op("div_200_7", 2'd2, 8'd200, 8'd7, 3'd6, DIV_ON ? 8'h1C : 8'h00, DIV_LAT);
    do_op("mod_200_7", 2'd3, 8'd200, 8'd7, 3'd7, DIV_ON ? 8'h04 : 8'h00, DIV_LAT);
    do_op("div_by0", 2'd2, 8'h5A, 8'h00, 3'd1, DIV_ON ? 8'hFF : 8'h00, DIV_LAT);
    do_op("mod_by0", 2'd3, 8'h5A, 8'h00, 3'd2, DIV_ON ? 8'h5A : 8'h00, DIV_LAT);

    // Abort mid-operation: 3*3 started, ignored start at +3, async reset at +5.
    op = 2'd0; a = 8'd3; b = 8'd3; dest_addr = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 1; i < 5; i++) begin
      if (rf_write_en) seen++;
      if (i == 3) begin a = 8'd9; b = 8'd9; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wen", 32'(rf_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rf_write_en || done) seen++;
      @(negedge clk);
    end
    check("abort_no_write", 32'(seen), 32'd0);

    do_op("mul_lo_9x9", 2'd0, 8'd9, 8'd9, 3'd0, 8'h51, 9);
    do_op("b2b_first", 2'd0, 8'd13, 8'd11, 3'd4, 8'h8F, 9);
    // do_op returns in the idle cycle right after WRITE, so this start is back-to-back.
    do_op("b2b_hi_255", 2'd1, 8'd255, 8'd255, 3'd6, 8'hFE, 9);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
